// File: rtl/if_pc_redirect_if.sv
// rtl/if_pc_redirect_if.sv - instruction fetch request bus between the next-PC unit and imem
interface if_pc_redirect_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] pc;
    logic        req_stale;

    modport master (output req_valid, output pc, output req_stale, input req_ready);
    modport slave  (input req_valid, input pc, input req_stale, output req_ready);
endinterface

// File: rtl/if_pc_redirect.sv
// rtl/if_pc_redirect.sv - IF-stage next-PC unit with EX redirect buffering and flush generation
module if_pc_redirect #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_pc_stall,
    input  logic                i_ex_redirect_valid,
    input  logic [63:0]         i_ex_redirect_target,
    if_pc_redirect_if.master    fetch,
    output logic                o_flush_if_id,
    output logic                o_flush_id_ex,
    output logic                o_misalign_trap,
    output logic                o_redirect_pending
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_pend;
    logic        r_trap;

    logic        w_misalign;
    logic [31:0] w_target;
    logic        w_accept;
    logic        w_unused_hi;

    // The EX adder is 64 bits wide but fetch addresses are 32 bits; the top half is dropped.
    assign w_unused_hi = ^i_ex_redirect_target[63:32];
    assign w_misalign  = |i_ex_redirect_target[1:0];
    assign w_target    = w_misalign ? TRAP_VEC : i_ex_redirect_target[31:0];
    assign w_accept    = r_valid & fetch.req_ready;

    // Next-PC state: a redirect that cannot be applied because the current request is
    // stuck on the bus is parked in r_pend until that request is finally accepted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_RUN;
            r_valid <= 1'b0;
            r_pc    <= RESET_PC;
            r_pend  <= 32'h0;
            r_trap  <= 1'b0;
        end else begin
            r_trap  <= i_ex_redirect_valid & w_misalign;
            // A presented, unaccepted request is never withdrawn; stall only blocks a new one.
            r_valid <= (r_valid & ~fetch.req_ready) | ~i_pc_stall;
            case (r_state)
                ST_RUN: begin
                    if (i_ex_redirect_valid) begin
                        if (!r_valid || w_accept) begin
                            r_pc <= w_target;
                        end else begin
                            r_pend  <= w_target;
                            r_state <= ST_HOLD;
                        end
                    end else if (w_accept) begin
                        r_pc <= r_pc + 32'd4;
                    end
                end
                ST_HOLD: begin
                    if (i_ex_redirect_valid) begin
                        r_pend <= w_target;
                    end
                    if (w_accept) begin
                        r_pc    <= i_ex_redirect_valid ? w_target : r_pend;
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign fetch.req_valid  = r_valid;
    assign fetch.pc         = r_pc;
    assign fetch.req_stale  = (r_state == ST_HOLD) & r_valid;

    assign o_flush_if_id      = i_ex_redirect_valid;
    assign o_flush_id_ex      = i_ex_redirect_valid;
    assign o_misalign_trap    = r_trap;
    assign o_redirect_pending = (r_state == ST_HOLD);

endmodule
